// File: rtl/skinny_sbox8_isw_iter.sv
// Masked SKINNY-128 8-bit S-box over D Boolean shares: eight NOR/XOR gadgets
// evaluated one at a time, two cycles each, with fresh randomness per gadget.
module skinny_sbox8_isw_iter #(
    parameter int D = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*D-1:0]         si,
    input  logic [4*D*(D-1)-1:0]   r,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [8*D-1:0]         bo,
    output logic                   out_valid,
    input  logic                   out_ready
);
    localparam int NP = D * (D - 1) / 2;
    localparam int RW = 4 * D * (D - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_r;
    logic [3:0]              cnt_r;
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic [8*D-1:0]          bo_r;
    logic [8*D-1:0]          b_r;
    logic [RW-1:0]           rnd_r;
    logic [8*D-1:0]          a_r;
    logic [D-1:0]            p_r;
    logic [D-1:0][D-1:0]     c_r;

    logic [2:0]              gate_s;
    logic [D-1:0]            x_s;
    logic [D-1:0]            y_s;
    logic [D-1:0]            z_s;
    logic [D-1:0]            p_s;
    logic [D-1:0][D-1:0]     c_s;
    logic [D-1:0]            f_s;
    logic [8*D-1:0]          a_next_s;
    logic [8*D-1:0]          bo_next_s;

    // Index of the unordered share pair (i<j) inside one gadget's mask slice.
    function automatic int pair_idx(input int i, input int j);
        return i * D - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

    // Place gadget results a0..a7 onto the S-box output bit positions.
    function automatic logic [7:0] out_perm(input logic [7:0] a);
        return {a[3], a[0], a[1], a[6], a[4], a[2], a[5], a[7]};
    endfunction

    assign gate_s    = cnt_r[3:1];
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign bo        = bo_r;

    // Operand selection for the active gadget; NOT is applied to share 0 only.
    always_comb begin
        logic [7:0] bs;
        logic [7:0] as;
        x_s = '0;
        y_s = '0;
        z_s = '0;
        for (int i = 0; i < D; i++) begin
            bs = b_r[8*i +: 8];
            as = a_r[8*i +: 8];
            case (gate_s)
                3'd0:    begin x_s[i] = bs[7]; y_s[i] = bs[6]; z_s[i] = bs[4]; end
                3'd1:    begin x_s[i] = bs[3]; y_s[i] = bs[2]; z_s[i] = bs[0]; end
                3'd2:    begin x_s[i] = bs[2]; y_s[i] = bs[1]; z_s[i] = bs[6]; end
                3'd3:    begin x_s[i] = as[0]; y_s[i] = as[1]; z_s[i] = bs[5]; end
                3'd4:    begin x_s[i] = as[1]; y_s[i] = bs[3]; z_s[i] = bs[1]; end
                3'd5:    begin x_s[i] = as[2]; y_s[i] = as[3]; z_s[i] = bs[7]; end
                3'd6:    begin x_s[i] = as[3]; y_s[i] = as[0]; z_s[i] = bs[3]; end
                default: begin x_s[i] = as[4]; y_s[i] = as[5]; z_s[i] = bs[2]; end
            endcase
        end
        x_s[0] = ~x_s[0];
        y_s[0] = ~y_s[0];
    end

    // First gadget cycle: per-share products and remasked cross products.
    always_comb begin
        p_s = '0;
        c_s = '0;
        for (int i = 0; i < D; i++) begin
            p_s[i] = (x_s[i] & y_s[i]) ^ z_s[i];
            for (int j = 0; j < D; j++) begin
                if (i < j) begin
                    c_s[i][j] = (x_s[i] & y_s[j]) ^ rnd_r[int'(gate_s) * NP + pair_idx(i, j)];
                end else if (i > j) begin
                    c_s[i][j] = (x_s[i] & y_s[j]) ^ rnd_r[int'(gate_s) * NP + pair_idx(j, i)];
                end else begin
                    c_s[i][j] = 1'b0;
                end
            end
        end
    end

    // Second gadget cycle: fold registered terms into share i (diagonal is zero).
    always_comb begin
        f_s       = '0;
        a_next_s  = a_r;
        bo_next_s = '0;
        for (int i = 0; i < D; i++) begin
            f_s[i] = p_r[i] ^ (^c_r[i]);
            if (cnt_r[0]) begin
                a_next_s[8*i + int'(gate_s)] = f_s[i];
            end else begin
                a_next_s[8*i + int'(gate_s)] = a_r[8*i + int'(gate_s)];
            end
        end
        for (int i = 0; i < D; i++) begin
            bo_next_s[8*i +: 8] = out_perm(a_next_s[8*i +: 8]);
        end
    end

    // Control FSM, capture registers and gadget datapath state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            bo_r        <= '0;
            b_r         <= '0;
            rnd_r       <= '0;
            a_r         <= '0;
            p_r         <= '0;
            c_r         <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        b_r        <= si;
                        rnd_r      <= r;
                        cnt_r      <= 4'd0;
                        in_ready_r <= 1'b0;
                        state_r    <= CALC;
                    end
                end
                CALC: begin
                    if (!cnt_r[0]) begin
                        p_r <= p_s;
                        c_r <= c_s;
                    end else begin
                        a_r <= a_next_s;
                    end
                    if (cnt_r == 4'd15) begin
                        bo_r        <= bo_next_s;
                        out_valid_r <= 1'b1;
                        cnt_r       <= 4'd0;
                        state_r     <= DONE;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= 4'd0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
